// File: rtl/axi_dma_burst_arbiter.sv
// Round-robin arbiter sharing one DMA backend burst port between NumChan
// frontend channels, with in-order completion routing back to the issuer.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   ch_req_i           per-channel burst request (burst_req_t)
//   ch_valid_i         per-channel request valid
//   ch_ready_o         per-channel accept, only for the granted channel
//   ch_done_o          registered one-cycle completion pulse per channel
//   ch_outstanding_o   in-flight burst count per channel
//   burst_req_o        request to backend (combinational mux)
//   valid_o, ready_i   backend request handshake
//   trans_complete_i   backend completion pulse, in issue order
//   busy_o             at least one burst outstanding
//   err_o              sticky: completion received with nothing in flight
//
// Build option: define AXI_DMA_ARB_PRIO_EN to give channel 0 strict
// priority over the round-robin channels 1..NumChan-1.
module axi_dma_burst_arbiter #(
  parameter int unsigned NumChan = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type burst_req_t = logic,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  burst_req_t [NumChan-1:0]       ch_req_i,
  input  logic [NumChan-1:0]             ch_valid_i,
  output logic [NumChan-1:0]             ch_ready_o,
  output logic [NumChan-1:0]             ch_done_o,
  output logic [NumChan-1:0][CntW-1:0]   ch_outstanding_o,
  output burst_req_t                     burst_req_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  input  logic                           trans_complete_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned IdxW = $clog2(NumChan);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t               rr_q;
  idx_t               rr_nxt;
  idx_t               lock_idx_q;
  logic               lock_q;
  idx_t               grant;
  idx_t               head;
  idx_t               fifo_q [MaxOutstanding];
  ptr_t               wr_q;
  ptr_t               rd_q;
  cnt_t               fill_q;
  cnt_t [NumChan-1:0] out_q;
  logic [NumChan-1:0] done_q;
  logic               err_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [NumChan-1:0] inc;
  logic [NumChan-1:0] dec;

  assign full  = fill_q == cnt_t'(MaxOutstanding);
  assign empty = fill_q == '0;
  assign head  = fifo_q[rd_q];

  // Scan from the rr pointer upward, wrapping; a held lock overrides.
  always_comb begin
    logic [IdxW:0] idx;
    logic          found;
    grant = rr_q;
    found = 1'b0;
    idx   = '0;
`ifdef AXI_DMA_ARB_PRIO_EN
    if (ch_valid_i[0]) begin
      grant = '0;
      found = 1'b1;
    end
`endif
    for (int i = 0; i < NumChan; i++) begin
      idx = {1'b0, rr_q} + (IdxW + 1)'(i);
      if (idx >= (IdxW + 1)'(NumChan)) begin
        idx = idx - (IdxW + 1)'(NumChan);
      end
      if (!found && ch_valid_i[idx[IdxW-1:0]]) begin
        grant = idx[IdxW-1:0];
        found = 1'b1;
      end
    end
    if (lock_q) begin
      grant = lock_idx_q;
    end
  end

  assign burst_req_o = ch_req_i[grant];
  assign valid_o     = |ch_valid_i & ~full;
  assign push        = valid_o & ready_i;
  assign pop         = trans_complete_i & ~empty;

  always_comb begin
    ch_ready_o = '0;
    if (push) begin
      ch_ready_o[grant] = 1'b1;
    end
  end

  always_comb begin
    rr_nxt = rr_q;
    if (push) begin
      if (grant == idx_t'(NumChan - 1)) begin
        rr_nxt = '0;
      end else begin
        rr_nxt = grant + idx_t'(1);
      end
`ifdef AXI_DMA_ARB_PRIO_EN
      if (grant == '0) begin
        rr_nxt = rr_q;
      end
`endif
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    if (push) begin
      inc[grant] = 1'b1;
    end
    if (pop) begin
      dec[head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q <= rr_nxt;
      if (push) begin
        lock_q <= 1'b0;
      end else if (valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= grant;
        wr_q         <= wr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_q <= rd_q + ptr_t'(1);
      end
      if (push && !pop) begin
        fill_q <= fill_q + cnt_t'(1);
      end else if (pop && !push) begin
        fill_q <= fill_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (inc[c] && !dec[c]) begin
          out_q[c] <= out_q[c] + cnt_t'(1);
        end else if (dec[c] && !inc[c]) begin
          out_q[c] <= out_q[c] - cnt_t'(1);
        end
      end
      done_q <= dec;
      if (trans_complete_i && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ch_done_o        = done_q;
  assign ch_outstanding_o = out_q;
  assign busy_o           = ~empty;
  assign err_o            = err_q;

endmodule

// File: tb/tb_axi_dma_burst_arbiter.sv
// Self-checking bench for axi_dma_burst_arbiter: queue-based reference
// model compared every cycle, plus directed literal expectations.
module tb_axi_dma_burst_arbiter;

  localparam int NCH  = 4;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  typedef logic [7:0] req_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  req_t [NCH-1:0]          ch_req;
  logic [NCH-1:0]          ch_valid = '0;
  logic [NCH-1:0]          ch_ready;
  logic [NCH-1:0]          ch_done;
  logic [NCH-1:0][CW-1:0]  ch_out;
  req_t                    burst_req;
  logic                    valid;
  logic                    ready = 1'b0;
  logic                    tc = 1'b0;
  logic                    busy;
  logic                    err;

  int errors = 0;
  int checks = 0;

  int       m_q[$];
  int       m_rr = 0;
  bit       m_locked = 0;
  int       m_lock_ch = 0;
  bit [3:0] m_done = '0;
  bit       m_err = 0;

  always #5 clk = ~clk;

  axi_dma_burst_arbiter #(
    .NumChan(NCH),
    .MaxOutstanding(MAXO),
    .burst_req_t(req_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .ch_req_i(ch_req),
    .ch_valid_i(ch_valid),
    .ch_ready_o(ch_ready),
    .ch_done_o(ch_done),
    .ch_outstanding_o(ch_out),
    .burst_req_o(burst_req),
    .valid_o(valid),
    .ready_i(ready),
    .trans_complete_i(tc),
    .busy_o(busy),
    .err_o(err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_locked) return m_lock_ch;
`ifdef AXI_DMA_ARB_PRIO_EN
    if (ch_valid[0]) return 0;
`endif
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_rr + i) % NCH;
      if (ch_valid[c]) return c;
    end
    return m_rr;
  endfunction

  function automatic int occ(int c);
    int n;
    n = 0;
    foreach (m_q[i]) if (m_q[i] == c) n++;
    return n;
  endfunction

  task automatic model_step();
    int g;
    bit v;
    bit hs;
    bit pp;
    if (!rst_n) begin
      m_q.delete();
      m_rr = 0;
      m_locked = 0;
      m_lock_ch = 0;
      m_done = '0;
      m_err = 0;
    end else begin
      g  = model_grant();
      v  = (|ch_valid) && (m_q.size() < MAXO);
      hs = v && ready;
      pp = tc && (m_q.size() != 0);
      m_done = pp ? 4'(1 << m_q[0]) : 4'b0;
      if (tc && m_q.size() == 0) m_err = 1;
      if (pp) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(g);
        m_locked = 0;
`ifdef AXI_DMA_ARB_PRIO_EN
        if (g != 0) m_rr = (g + 1) % NCH;
`else
        m_rr = (g + 1) % NCH;
`endif
      end else if (v) begin
        m_locked = 1;
        m_lock_ch = g;
      end
    end
  endtask

  task automatic compare();
    int       g;
    bit       ev;
    bit [3:0] er;
    g  = model_grant();
    ev = (|ch_valid) && (m_q.size() < MAXO);
    er = (ev && ready) ? 4'(1 << g) : 4'b0;
    chk("m_valid_o", 32'(valid), 32'(ev));
    chk("m_ch_ready_o", 32'(ch_ready), 32'(er));
    chk("m_ch_done_o", 32'(ch_done), 32'(m_done));
    chk("m_busy_o", 32'(busy), 32'(m_q.size() != 0));
    chk("m_err_o", 32'(err), 32'(m_err));
    for (int c = 0; c < NCH; c++) begin
      chk("m_outstanding", 32'(ch_out[c]), 32'(occ(c)));
    end
    if (ev) chk("m_burst_req_o", 32'(burst_req), 32'h0A0 + 32'(g));
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) ch_req[c] = 8'hA0 + 8'(c);
    nxt();
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", 32'(ch_out), 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // round robin over all channels until the FIFO fills
    ch_valid = '1;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(ch_ready), 32'(1 << k));
      nxt();
    end
    @(negedge clk);
    chk("full_valid", 32'(valid), 0);
    chk("full_ready", 32'(ch_ready), 0);
    chk("rr_out", 32'(ch_out), 32'h249);
    nxt();
    ch_valid = '0;
    tc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk("rr_done", 32'(ch_done), 32'(1 << (k - 1)));
      nxt();
    end
    tc = 1'b0;
    @(negedge clk);
    chk("rr_done_last", 32'(ch_done), 32'h8);
    chk("rr_busy", 32'(busy), 0);
    nxt();

    // lock held on channel 2 while channel 1 joins
    ch_valid = 4'b0100;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_req", 32'(burst_req), 32'hA2);
      chk("lock_rdy", 32'(ch_ready), 0);
      nxt();
      ch_valid = 4'b0110;
    end
    ready = 1'b1;
    @(negedge clk);
    chk("lock_req4", 32'(burst_req), 32'hA2);
    chk("lock_rdy4", 32'(ch_ready), 32'h4);
    nxt();
    ch_valid = 4'b0010;
    @(negedge clk);
    chk("lock_next", 32'(ch_ready), 32'h2);
    chk("lock_next_req", 32'(burst_req), 32'hA1);
    nxt();
    ch_valid = '0;
    tc = 1'b1;
    nxt();
    @(negedge clk);
    chk("lock_done2", 32'(ch_done), 32'h4);
    nxt();
    tc = 1'b0;
    @(negedge clk);
    chk("lock_done1", 32'(ch_done), 32'h2);
    nxt();

    // fill from channel 1, then a pop frees one slot a cycle later
    ch_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fill_rdy", 32'(ch_ready), 32'h2);
      nxt();
    end
    tc = 1'b1;
    @(negedge clk);
    chk("fill_valid", 32'(valid), 0);
    chk("fill_rdy0", 32'(ch_ready), 0);
    chk("fill_out", 32'(ch_out[1]), 4);
    nxt();
    tc = 1'b0;
    @(negedge clk);
    chk("fill_done", 32'(ch_done), 32'h2);
    chk("fill_push", 32'(ch_ready), 32'h2);
    nxt();
    ch_valid = '0;
    @(negedge clk);
    chk("fill_out2", 32'(ch_out[1]), 4);
    nxt();
    tc = 1'b1;
    for (int k = 0; k < 4; k++) nxt();
    tc = 1'b0;
    nxt();

    // completion routing 3,0,3
    ready = 1'b1;
    ch_valid = 4'b1000;
    @(negedge clk);
    chk("rt_rdy3", 32'(ch_ready), 32'h8);
    nxt();
    ch_valid = 4'b0001;
    @(negedge clk);
    chk("rt_rdy0", 32'(ch_ready), 32'h1);
    nxt();
    ch_valid = 4'b1000;
    nxt();
    ch_valid = '0;
    tc = 1'b1;
    @(negedge clk);
    chk("rt_out3", 32'(ch_out[3]), 2);
    chk("rt_out0", 32'(ch_out[0]), 1);
    nxt();
    @(negedge clk);
    chk("rt_done_a", 32'(ch_done), 32'h8);
    nxt();
    @(negedge clk);
    chk("rt_done_b", 32'(ch_done), 32'h1);
    chk("rt_busy", 32'(busy), 1);
    nxt();
    tc = 1'b0;
    @(negedge clk);
    chk("rt_done_c", 32'(ch_done), 32'h8);
    chk("rt_idle", 32'(busy), 0);
    nxt();

    // push and pop on the same channel in one cycle
    ch_valid = 4'b0100;
    nxt();
    tc = 1'b1;
    @(negedge clk);
    chk("pp_rdy", 32'(ch_ready), 32'h4);
    chk("pp_out_a", 32'(ch_out[2]), 1);
    nxt();
    ch_valid = '0;
    @(negedge clk);
    chk("pp_out_b", 32'(ch_out[2]), 1);
    chk("pp_done", 32'(ch_done), 32'h4);
    nxt();
    tc = 1'b0;
    nxt();

`ifdef AXI_DMA_ARB_PRIO_EN
    // channel 0 strict priority over channel 2
    ch_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio_0", 32'(ch_ready), 32'h1);
      nxt();
      tc = 1'b1;
    end
    ch_valid = 4'b0100;
    @(negedge clk);
    chk("prio_2", 32'(ch_ready), 32'h4);
    nxt();
    ch_valid = '0;
    nxt();
    tc = 1'b0;
    nxt();
`endif

    // completion with nothing outstanding, then reset mid-flight
    @(negedge clk);
    chk("err_clear", 32'(err), 0);
    nxt();
    tc = 1'b1;
    nxt();
    tc = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(err), 1);
    chk("err_nodone", 32'(ch_done), 0);
    nxt();
    ch_valid = 4'b0001;
    nxt();
    ch_valid = 4'b0010;
    nxt();
    ch_valid = '0;
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_out", 32'(ch_out), 0);
    chk("ar_done", 32'(ch_done), 0);
    chk("ar_valid", 32'(valid), 0);
    chk("ar_ready", 32'(ch_ready), 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
    tc = 1'b1;
    nxt();
    tc = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 32'(err), 1);
    chk("post_rst_done", 32'(ch_done), 0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_dma_burst_arbiter.md
Name: axi_dma_burst_arbiter

Overview:
- Shares one DMA backend burst-request port between NumChan frontend channels, each issuing 1D burst requests.
- Arbitrates round-robin and holds the grant stable until the backend accepts the request.
- Records the issuing channel of every accepted burst in an in-order tracking FIFO, and routes each backend completion pulse back to its owning channel.
- Sits between the per-core or per-cluster DMA frontends and the single backend instance.

Parameters:
- NumChan, 4, number of requesting channels (>=2).
- MaxOutstanding, 8, depth of the tracking FIFO; maximum number of bursts accepted but not yet completed (>=2, power of two).
- burst_req_t, logic, 1D burst request struct, passed through unmodified.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ch_req_i  in  NumChan x burst_req_t  per-channel burst request.
- ch_valid_i  in  NumChan  per-channel request valid.
- ch_ready_o  out  NumChan  per-channel request accepted.
- ch_done_o  out  NumChan  one-cycle completion pulse per channel.
- ch_outstanding_o  out  NumChan x $clog2(MaxOutstanding+1)  in-flight bursts per channel.
- burst_req_o  out  burst_req_t  request to the backend.
- valid_o  out  1  request valid to the backend.
- ready_i  in  1  backend ready.
- trans_complete_i  in  1  backend completion pulse, one per burst, in issue order.
- busy_o  out  1  at least one burst is outstanding.
- err_o  out  1  sticky: completion pulse received while the FIFO was empty.

Behaviour:
- Reset values: all outputs 0, rr pointer 0, FIFO empty, lock cleared.
- Handshake rule: a channel that raises ch_valid_i must hold it, with ch_req_i stable, until ch_ready_o.
- Grant selection:
  - When not locked, grant = first channel with ch_valid_i set, scanning from the rr pointer upward and wrapping modulo NumChan.
  - burst_req_o = ch_req_i[grant]; valid_o = |ch_valid_i & !fifo_full.
- Lock:
  - If valid_o=1 and ready_i=0, set lock_q and store grant in lock_idx_q.
  - While lock_q is set, grant = lock_idx_q regardless of other valids.
  - Clear the lock on handshake.
- Handshake (valid_o & ready_i):
  - Only ch_ready_o[grant] is asserted, combinationally with ready_i; all other ch_ready_o bits are 0.
  - Push grant into the FIFO.
  - rr pointer = grant+1, wrapping at NumChan.
  - Increment ch_outstanding_o[grant].
- Zero added latency on the request path: purely combinational mux from ch_req_i to burst_req_o.
- FIFO full:
  - valid_o=0 and all ch_ready_o=0.
  - A pop in the same cycle does not allow a push; no bypass. The push happens the following cycle.
- Completion (trans_complete_i=1 and FIFO not empty):
  - Pop the head index h.
  - ch_done_o[h] pulses exactly one cycle later (registered).
  - Decrement ch_outstanding_o[h] in the same cycle as the pop.
- Completion with FIFO empty: pop ignored, no done pulse, err_o set; err_o clears only on reset.
- Simultaneous push and pop (FIFO not full): both take effect.
  - If they target the same channel, that channel's count is unchanged.
  - FIFO occupancy is unchanged.
- Arithmetic: per-channel counters never exceed MaxOutstanding; FIFO pointers wrap at MaxOutstanding.
- busy_o = FIFO not empty (registered, derived from the count).
- Reset mid-operation clears the FIFO, counters and lock immediately. In-flight backend completions arriving after reset are treated as completions with an empty FIFO and set err_o.

Optional Feature:
- Macro: AXI_DMA_ARB_PRIO_EN.
- Defined:
  - Channel 0 has strict priority: when not locked and ch_valid_i[0]=1, grant = 0.
  - A channel-0 grant does not move the rr pointer.
  - Channels 1..NumChan-1 stay round-robin among themselves.
  - Lock behaviour is unchanged, so a locked grant is never preempted.
- Undefined: all channels are pure round-robin as described above.

Test Plan:
- Round-robin, NumChan=4, all valid, ready_i=1: grants 0,1,2,3,0 on consecutive cycles; ch_outstanding_o = 1 per channel after 4 cycles (the fifth grant, to channel 0, needs MaxOutstanding>=5 or completions, otherwise it stalls on FIFO full).
- Lock: ch 2 valid, ready_i low 3 cycles, ch 1 raises valid in cycle 2: burst_req_o stays ch 2 for 4 cycles; ch_ready_o[2] only on cycle 4; ch 1 granted next.
- Full, MaxOutstanding=4: issue 4 from ch 1, no completions: valid_o=0 and ch_ready_o=0. A trans_complete_i pulse gives ch_done_o[1] one cycle later, and the fifth push happens the cycle after the pop.
- Completion routing: issue ch 3, ch 0, ch 3, then 3 completion pulses: ch_done_o pulses on ch 3, ch 0, ch 3 in order; busy_o falls one cycle after the last pop.
- Error and reset: trans_complete_i with FIFO empty sets err_o=1, no ch_done_o. Assert rst_ni low with 2 outstanding: all outputs 0 and busy_o=0.
- AXI_DMA_ARB_PRIO_EN: ch 0 and ch 2 held valid, ch 0 re-asserting every cycle: ch 0 wins every cycle; ch 2 is granted only when ch 0 drops valid.
